// File: rtl/adc_xy_avg.sv
// adc_xy_avg: block-averages N = 2**AVG_SHIFT paired X/Y ADC samples and
// presents each average through a one-entry valid/ready output register.
// When a new average finishes while the previous one is still waiting to be
// taken, the new average is dropped and a saturating counter records it.
module adc_xy_avg #(
    parameter int DATA_BITS = 10,
    parameter int AVG_SHIFT = 2,
    parameter int OVR_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] adc_x,
    input  logic [DATA_BITS-1:0] adc_y,
    input  logic                 sample_en,
    input  logic                 clear,
    output logic                 avg_valid,
    input  logic                 avg_ready,
    output logic [DATA_BITS-1:0] avg_x,
    output logic [DATA_BITS-1:0] avg_y,
    output logic [OVR_BITS-1:0]  overrun_cnt
);

    // The accumulator is wide enough to hold N full-scale samples.
    localparam int ACC_W = DATA_BITS + AVG_SHIFT;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

    out_state_t            state, state_nxt;
    logic [ACC_W-1:0]      acc_x, acc_y;
    logic [ACC_W-1:0]      sum_x, sum_y;
    logic [AVG_SHIFT-1:0]  cnt;
    logic                  accept, done, hs, load, ovr_inc;

    // clear takes priority, so a sample arriving with clear is discarded.
    assign accept = sample_en && !clear;
    // cnt is exactly AVG_SHIFT bits wide, so all-ones marks the last sample.
    assign done   = accept && (cnt == '1);
    assign hs     = avg_valid && avg_ready;

    // The current sample is included in the sum, so a window completes
    // on the same edge that accepts its last sample.
    assign sum_x  = acc_x + {{AVG_SHIFT{1'b0}}, adc_x};
    assign sum_y  = acc_y + {{AVG_SHIFT{1'b0}}, adc_y};

    assign avg_valid = (state == FULL);

    // Accumulate accepted samples and restart the window on completion or clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else if (clear || done) begin
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else if (accept) begin
            acc_x <= sum_x;
            acc_y <= sum_y;
            cnt   <= cnt + 1'b1;
        end
    end

    // Output register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Next state: decide whether a new result loads or counts as an overrun.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ovr_inc   = 1'b0;
        case (state)
            EMPTY: begin
                if (done) begin
                    state_nxt = FULL;
                    load      = 1'b1;
                end
            end
            FULL: begin
                if (hs && done) begin
                    load = 1'b1;
                end else if (hs) begin
                    state_nxt = EMPTY;
                end else if (done) begin
                    ovr_inc = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Result register: shifting right by AVG_SHIFT gives the truncated mean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avg_x <= '0;
            avg_y <= '0;
        end else if (load) begin
            avg_x <= sum_x[ACC_W-1:AVG_SHIFT];
            avg_y <= sum_y[ACC_W-1:AVG_SHIFT];
        end
    end

    // Dropped-average counter; it saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           overrun_cnt <= '0;
        else if (ovr_inc && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
    end

endmodule

// File: tb/tb_adc_xy_avg.sv
// Directed bench for adc_xy_avg (DATA_BITS=10, AVG_SHIFT=2). OVR_BITS is
// reduced to 2 so that overrun saturation can be reached in a few windows.
module tb_adc_xy_avg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] adc_x = '0;
    logic [9:0] adc_y = '0;
    logic       sample_en = 1'b0;
    logic       clear = 1'b0;
    logic       avg_valid;
    logic       avg_ready = 1'b0;
    logic [9:0] avg_x, avg_y;
    logic [1:0] overrun_cnt;

    int checks = 0;
    int errors = 0;

    adc_xy_avg #(.DATA_BITS(10), .AVG_SHIFT(2), .OVR_BITS(2)) dut (
        .clk(clk), .reset(reset), .adc_x(adc_x), .adc_y(adc_y),
        .sample_en(sample_en), .clear(clear), .avg_valid(avg_valid),
        .avg_ready(avg_ready), .avg_x(avg_x), .avg_y(avg_y),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One accepted sample; returns 1 time unit after the edge.
    task automatic smp(input int x, input int y);
        adc_x = 10'(x);
        adc_y = 10'(y);
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 32'(avg_valid), 0);
        chk("rst_x", 32'(avg_x), 0);
        chk("rst_y", 32'(avg_y), 0);
        chk("rst_ovr", 32'(overrun_cnt), 0);
        @(negedge clk); reset = 1'b0;

        // Basic average: 406/4 -> 101, 3/4 -> 0
        avg_ready = 1'b1;
        smp(100, 0); smp(101, 0); smp(102, 0);
        chk("basic_pre_valid", 32'(avg_valid), 0);
        smp(103, 3);
        chk("basic_valid", 32'(avg_valid), 1);
        chk("basic_x", 32'(avg_x), 101);
        chk("basic_y", 32'(avg_y), 0);
        idle();
        chk("basic_drop", 32'(avg_valid), 0);

        // Full scale, then 0,0,0,1 -> 0
        repeat (4) smp(1023, 1023);
        chk("fs_valid", 32'(avg_valid), 1);
        chk("fs_x", 32'(avg_x), 1023);
        chk("fs_y", 32'(avg_y), 1023);
        smp(0, 0); smp(0, 0); smp(0, 0); smp(1, 1);
        chk("small_valid", 32'(avg_valid), 1);
        chk("small_x", 32'(avg_x), 0);
        chk("small_y", 32'(avg_y), 0);
        idle();
        chk("small_drop", 32'(avg_valid), 0);

        // Overrun: second window dropped while first is held
        avg_ready = 1'b0;
        repeat (4) smp(10, 0);
        chk("ovr_first_x", 32'(avg_x), 10);
        repeat (4) smp(20, 0);
        chk("ovr_hold_x", 32'(avg_x), 10);
        chk("ovr_valid", 32'(avg_valid), 1);
        chk("ovr_cnt", 32'(overrun_cnt), 1);
        avg_ready = 1'b1;
        idle();
        chk("ovr_hs_drop", 32'(avg_valid), 0);

        // Handshake and completion on the same edge
        avg_ready = 1'b0;
        repeat (4) smp(10, 0);
        chk("sim_hold_x", 32'(avg_x), 10);
        repeat (3) smp(40, 0);
        avg_ready = 1'b1;
        smp(40, 0);
        chk("sim_valid", 32'(avg_valid), 1);
        chk("sim_x", 32'(avg_x), 40);
        chk("sim_ovr", 32'(overrun_cnt), 1);
        idle();
        chk("sim_drop", 32'(avg_valid), 0);

        // Clear (with a discarded sample) and gapped samples
        smp(500, 500); smp(500, 500);
        clear = 1'b1;
        smp(500, 500);
        clear = 1'b0;
        chk("clr_ovr", 32'(overrun_cnt), 1);
        for (int i = 0; i < 4; i++) begin
            smp(8, 8);
            idle(); idle();
            if (i == 2) chk("gap_pre_valid", 32'(avg_valid), 0);
        end
        // Result landed on the 4th sample edge and was taken on the next idle.
        chk("gap_taken", 32'(avg_valid), 0);
        chk("gap_x", 32'(avg_x), 8);
        chk("gap_y", 32'(avg_y), 8);

        // Asynchronous reset mid-window
        repeat (3) smp(900, 900);
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(avg_valid), 0);
        chk("arst_x", 32'(avg_x), 0);
        chk("arst_y", 32'(avg_y), 0);
        chk("arst_ovr", 32'(overrun_cnt), 0);
        @(negedge clk); reset = 1'b0;
        smp(4, 4);
        chk("arst_partial", 32'(avg_valid), 0);
        smp(4, 4); smp(4, 4); smp(4, 4);
        chk("arst_valid2", 32'(avg_valid), 1);
        chk("arst_x2", 32'(avg_x), 4);

        // Overrun counter saturation (2-bit counter tops out at 3)
        avg_ready = 1'b0;
        repeat (3) repeat (4) smp(7, 7);
        chk("sat_cnt3", 32'(overrun_cnt), 3);
        repeat (4) smp(7, 7);
        chk("sat_hold", 32'(overrun_cnt), 3);
        chk("sat_x", 32'(avg_x), 4);

        // Ready while empty has no effect
        avg_ready = 1'b1;
        idle();
        idle();
        chk("empty_ready", 32'(avg_valid), 0);
        chk("empty_ovr", 32'(overrun_cnt), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
